// File: rtl/soc_bus_xbar.sv
// NB_MASTER x NB_SLAVE request/grant crossbar: region decode, per-slave round-robin,
// one outstanding transaction per master and per slave, internal decode-error responder.
module soc_bus_xbar #(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]      start_addr_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0]      end_addr_i,
  input  logic [NB_MASTER-1:0]                m_req_i,
  input  logic [NB_MASTER*ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [NB_MASTER-1:0]                m_we_i,
  input  logic [NB_MASTER*(DATA_WIDTH/8)-1:0] m_be_i,
  input  logic [NB_MASTER*DATA_WIDTH-1:0]     m_wdata_i,
  output logic [NB_MASTER-1:0]                m_gnt_o,
  output logic [NB_MASTER-1:0]                m_rvalid_o,
  output logic [NB_MASTER*DATA_WIDTH-1:0]     m_rdata_o,
  output logic [NB_MASTER-1:0]                m_err_o,
  output logic [NB_SLAVE-1:0]                 s_req_o,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0]      s_addr_o,
  output logic [NB_SLAVE-1:0]                 s_we_o,
  output logic [NB_SLAVE*(DATA_WIDTH/8)-1:0]  s_be_o,
  output logic [NB_SLAVE*DATA_WIDTH-1:0]      s_wdata_o,
  input  logic [NB_SLAVE-1:0]                 s_gnt_i,
  input  logic [NB_SLAVE-1:0]                 s_rvalid_i,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0]      s_rdata_i,
  input  logic [NB_SLAVE-1:0]                 s_err_i,
  output logic                                proto_err_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int MW   = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int SW   = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;

  localparam logic [0:0] M_IDLE = 1'b0;
  localparam logic [0:0] M_WAIT = 1'b1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Handshake: a master request is accepted in the cycle m_req_i & m_gnt_o; the
  // single response arrives later as a one-cycle m_rvalid_o. Slave side mirrors
  // this with s_req_o & s_gnt_i, then one s_rvalid_i.
  logic [NB_MASTER-1:0] m_state_q;
  logic [NB_SLAVE-1:0]  s_state_q;
  logic [MW-1:0]        owner_q [NB_SLAVE];
  logic [MW-1:0]        rr_q    [NB_SLAVE];
  logic [NB_MASTER-1:0] derr_q;
  logic                 proto_err_q;

  logic [NB_MASTER-1:0] hit;
  logic [NB_MASTER-1:0] cand;
  logic [NB_MASTER-1:0] derr_gnt;
  logic [SW-1:0]        tgt [NB_MASTER];
  logic [NB_SLAVE-1:0]  win_vld;
  logic [MW-1:0]        win [NB_SLAVE];
  logic [NB_SLAVE-1:0]  spurious;
  logic [MW:0]          idx_w;
  logic [MW-1:0]        idx;

  // Descending scan so the lowest matching region wins on overlap.
  always_comb begin
    for (int m = 0; m < NB_MASTER; m++) begin
      hit[m] = 1'b0;
      tgt[m] = '0;
      for (int s = NB_SLAVE - 1; s >= 0; s--) begin
        if (m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= start_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH] &&
            m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] <= end_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
          hit[m] = 1'b1;
          tgt[m] = SW'(s);
        end
      end
      cand[m]     = m_req_i[m] && (m_state_q[m] == M_IDLE) && hit[m];
      derr_gnt[m] = m_req_i[m] && (m_state_q[m] == M_IDLE) && !hit[m];
    end
  end

  always_comb begin
    idx_w = '0;
    idx   = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      win_vld[s] = 1'b0;
      win[s]     = '0;
      for (int k = 0; k < NB_MASTER; k++) begin
        idx_w = {1'b0, rr_q[s]} + (MW+1)'(k);
        if (idx_w >= (MW+1)'(NB_MASTER)) idx_w = idx_w - (MW+1)'(NB_MASTER);
        idx = idx_w[MW-1:0];
        if (!win_vld[s] && (s_state_q[s] == S_IDLE) && cand[idx] && (tgt[idx] == SW'(s))) begin
          win_vld[s] = 1'b1;
          win[s]     = idx;
        end
      end
    end
  end

  always_comb begin
    s_req_o   = win_vld;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_gnt_o   = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      if (win_vld[s]) begin
        s_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_i[win[s]*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o[s]                             = m_we_i[win[s]];
        s_be_o[s*BE_W +: BE_W]                = m_be_i[win[s]*BE_W +: BE_W];
        s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[win[s]*DATA_WIDTH +: DATA_WIDTH];
        m_gnt_o[win[s]]                       = s_gnt_i[s];
      end
    end
    for (int m = 0; m < NB_MASTER; m++) begin
      if (derr_gnt[m]) m_gnt_o[m] = 1'b1;
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    spurious   = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      if (s_state_q[s] == S_BUSY) begin
        m_err_o[owner_q[s]] = s_err_i[s];
        if (s_rvalid_i[s]) begin
          m_rvalid_o[owner_q[s]]                          = 1'b1;
          m_rdata_o[owner_q[s]*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        spurious[s] = s_rvalid_i[s];
      end
    end
    // Decode-error response: one cycle after the internal grant, data stays 0.
    for (int m = 0; m < NB_MASTER; m++) begin
      if (derr_q[m]) begin
        m_rvalid_o[m] = 1'b1;
        m_err_o[m]    = 1'b1;
      end
    end
  end

  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_state_q   <= {NB_MASTER{M_IDLE}};
      s_state_q   <= {NB_SLAVE{S_IDLE}};
      derr_q      <= '0;
      proto_err_q <= 1'b0;
      for (int s = 0; s < NB_SLAVE; s++) begin
        owner_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      derr_q      <= derr_gnt;
      proto_err_q <= |spurious;
      for (int m = 0; m < NB_MASTER; m++) begin
        if (m_state_q[m] == M_IDLE && m_req_i[m] && m_gnt_o[m]) m_state_q[m] <= M_WAIT;
        else if (m_state_q[m] == M_WAIT && m_rvalid_o[m])      m_state_q[m] <= M_IDLE;
      end
      // A slave freed this cycle cannot be re-granted until the next one.
      for (int s = 0; s < NB_SLAVE; s++) begin
        if (s_state_q[s] == S_BUSY && s_rvalid_i[s]) begin
          s_state_q[s] <= S_IDLE;
        end else if (win_vld[s] && s_gnt_i[s]) begin
          s_state_q[s] <= S_BUSY;
          owner_q[s]   <= win[s];
          rr_q[s]      <= (win[s] == MW'(NB_MASTER - 1)) ? '0 : win[s] + MW'(1);
        end
      end
    end
  end

endmodule
